// File: rtl/cmd_frame_decoder.sv
// -----------------------------------------------------------------------------
// cmd_frame_decoder
//
// Parses the 5-byte host command frame  HDR0 HDR1 CTRL VALUE CSUM  arriving
// from the UART receiver and drives the registered control/value command
// buses consumed by the multi-channel splicing top.
// CSUM = (CTRL + VALUE) mod 256.
//
// Ports:
//   clk            system clock (single domain)
//   rst            asynchronous, active-high reset
//   rx_data[7:0]   received byte, qualified by rx_valid
//   rx_valid       one-cycle strobe, one byte per strobe
//   ctrl_command   registered layout/control command
//   value_command  registered value / focus-source command
//   cmd_update     one-cycle pulse when the command outputs are loaded
//   cmd_err        one-cycle pulse when a frame is rejected
//   err_cnt        saturating count of rejected frames
//   busy           high while a frame is in progress (state != S_IDLE)
//
// Optional build macro:
//   CMD_TIMEOUT_EN  adds an inter-byte timeout of TIMEOUT_CYCLES clocks; an
//                   expired partial frame is dropped and counted as an error.
//
// Handshake: rx_valid is a strobe with no back-pressure; every cycle with
// rx_valid=1 consumes exactly one byte, cycles without it never change state
// (except for the optional timeout). cmd_update/cmd_err appear one clock
// after the CSUM byte and are mutually exclusive.
// -----------------------------------------------------------------------------
module cmd_frame_decoder #(
  parameter logic [7:0]  HDR0           = 8'h55,
  parameter logic [7:0]  HDR1           = 8'hAA,
  parameter logic [3:0]  RST_CTRL       = 4'd0,
  parameter logic [3:0]  RST_VALUE      = 4'd1,
  parameter logic [3:0]  FOCUS_CTRL     = 4'd1,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] ctrl_command,
  output logic [3:0] value_command,
  output logic       cmd_update,
  output logic       cmd_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_CTRL,
    S_VAL,
    S_CSUM
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] ctrl_reg, ctrl_reg_nxt;
  logic [7:0] val_reg, val_reg_nxt;
  logic [7:0] csum_exp;
  logic       frame_ok;
  logic       load_cmd;
  logic       reject;
  logic       tmo_hit;

  // Frame validity, evaluated against the CSUM byte currently on rx_data.
  assign csum_exp = ctrl_reg + val_reg;

  always_comb begin
    frame_ok = (rx_data == csum_exp) &&
               (ctrl_reg[7:4] == 4'd0) && (val_reg[7:4] == 4'd0);
    // The focus command only accepts the four defined sources.
    if (ctrl_reg[3:0] == FOCUS_CTRL &&
        (val_reg[3:0] < 4'd1 || val_reg[3:0] > 4'd4))
      frame_ok = 1'b0;
  end

`ifdef CMD_TIMEOUT_EN
  logic [23:0] tmo_cnt;

  // A byte in the same cycle always wins over the timeout.
  assign tmo_hit = (state != S_IDLE) && !rx_valid &&
                   (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= 24'd0;
    else if (rx_valid || state == S_IDLE || tmo_hit)
      tmo_cnt <= 24'd0;
    else
      tmo_cnt <= tmo_cnt + 24'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt    = state;
    ctrl_reg_nxt = ctrl_reg;
    val_reg_nxt  = val_reg;
    load_cmd     = 1'b0;
    reject       = 1'b0;
    if (rx_valid) begin
      case (state)
        S_IDLE: begin
          if (rx_data == HDR0) state_nxt = S_HDR1;
        end
        S_HDR1: begin
          if (rx_data == HDR1)      state_nxt = S_CTRL;
          else if (rx_data == HDR0) state_nxt = S_HDR1; // resync on repeated HDR0
          else                      state_nxt = S_IDLE;
        end
        S_CTRL: begin
          ctrl_reg_nxt = rx_data;
          state_nxt    = S_VAL;
        end
        S_VAL: begin
          val_reg_nxt = rx_data;
          state_nxt   = S_CSUM;
        end
        S_CSUM: begin
          state_nxt = S_IDLE;
          if (frame_ok) load_cmd = 1'b1;
          else          reject   = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = S_IDLE;
      reject    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ctrl_reg      <= 8'd0;
      val_reg       <= 8'd0;
      ctrl_command  <= RST_CTRL;
      value_command <= RST_VALUE;
      cmd_update    <= 1'b0;
      cmd_err       <= 1'b0;
      err_cnt       <= 8'd0;
      busy          <= 1'b0;
    end else begin
      state      <= state_nxt;
      ctrl_reg   <= ctrl_reg_nxt;
      val_reg    <= val_reg_nxt;
      busy       <= (state_nxt != S_IDLE);
      cmd_update <= load_cmd;
      cmd_err    <= reject;
      if (load_cmd) begin
        ctrl_command  <= ctrl_reg[3:0];
        value_command <= val_reg[3:0];
      end
      if (reject && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_decoder
//
// Self-checking bench for cmd_frame_decoder. The reference model keeps the
// bytes of the partial frame in a queue and judges a frame once five bytes
// are present; expected outputs are derived from that queue.
// Define CMD_TIMEOUT_EN to build the DUT with TIMEOUT_CYCLES=100 and run the
// timeout scenario.
// -----------------------------------------------------------------------------
module tb_cmd_frame_decoder;

  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] ctrl_command;
  logic [3:0] value_command;
  logic       cmd_update;
  logic       cmd_err;
  logic [7:0] err_cnt;
  logic       busy;

  always #5 clk = ~clk;

`ifdef CMD_TIMEOUT_EN
  cmd_frame_decoder #(.TIMEOUT_CYCLES(24'd100)) dut (
`else
  cmd_frame_decoder dut (
`endif
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .ctrl_command  (ctrl_command),
    .value_command (value_command),
    .cmd_update    (cmd_update),
    .cmd_err       (cmd_err),
    .err_cnt       (err_cnt),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];   // bytes of the frame currently being collected
  logic [3:0] m_ctrl;
  logic [3:0] m_val;
  logic       m_upd;
  logic       m_err;
  logic [7:0] m_cnt;
  int         m_idle;

  function automatic void model_reset();
    exp_q.delete();
    m_ctrl = 4'd0;
    m_val  = 4'd1;
    m_upd  = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 8'd0;
    m_idle = 0;
  endfunction

  function automatic void model_reject();
    m_err = 1'b1;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int c, v, s;
    bit ok;
    exp_q.push_back(b);
    if (exp_q.size() == 1 && exp_q[0] != 8'h55) begin
      exp_q.delete();
    end else if (exp_q.size() == 2 && exp_q[1] != 8'hAA) begin
      if (exp_q[1] == 8'h55) void'(exp_q.pop_front());
      else exp_q.delete();
    end else if (exp_q.size() == 5) begin
      c  = int'(exp_q[2]);
      v  = int'(exp_q[3]);
      s  = int'(exp_q[4]);
      ok = ((c + v) % 256 == s) && c < 16 && v < 16 &&
           !(c == 1 && (v < 1 || v > 4));
      if (ok) begin
        m_ctrl = 4'(c);
        m_val  = 4'(v);
        m_upd  = 1'b1;
      end else begin
        model_reject();
      end
      exp_q.delete();
    end
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: present (v, d), take the edge, advance the model, and
  // leave the time 1 unit after the edge so outputs can be sampled.
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = v ? d : $urandom_range(0, 255);
    @(posedge clk);
    m_upd = 1'b0;
    m_err = 1'b0;
    if (v) begin
      m_idle = 0;
      model_byte(d);
    end else begin
`ifdef CMD_TIMEOUT_EN
      if (exp_q.size() != 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          exp_q.delete();
          m_idle = 0;
          model_reject();
        end
      end
`endif
    end
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;          // asserted between edges: asynchronous
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00);
      checks++;
      if (ctrl_command !== 4'd0 || value_command !== 4'd1 || err_cnt !== 8'd0 ||
          busy !== 1'b0 || cmd_update !== 1'b0 || cmd_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: ctrl=%0d val=%0d cnt=%0d busy=%b upd=%b err=%b, required 0/1/0/0/0/0",
                 ctrl_command, value_command, err_cnt, busy, cmd_update, cmd_err);
      end
    end
  endtask

  task automatic test_basic();
    send(8'h55); send(8'hAA);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    send(8'h01); send(8'h03); send(8'h04);
    checks++;
    if (ctrl_command !== 4'd1 || value_command !== 4'd3 || cmd_update !== 1'b1 ||
        cmd_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame: ctrl=%0d val=%0d upd=%b err=%b busy=%b, required 1/3/1/0/0",
               ctrl_command, value_command, cmd_update, cmd_err, busy);
    end
    drive(1'b0, 8'h00);
    checks++;
    if (cmd_update !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_len: upd=%b required 0", cmd_update);
    end
  endtask

  task automatic test_bad_csum();
    send(8'h55); send(8'hAA); send(8'h01); send(8'h03); send(8'h05);
    checks++;
    if (cmd_err !== 1'b1 || cmd_update !== 1'b0 || err_cnt !== 8'd1 ||
        ctrl_command !== 4'd1 || value_command !== 4'd3) begin
      errors++;
      $display("FAIL bad_csum: err=%b upd=%b cnt=%0d ctrl=%0d val=%0d, required 1/0/1/1/3",
               cmd_err, cmd_update, err_cnt, ctrl_command, value_command);
    end
    // back-to-back: next HDR0 directly after the CSUM byte
    send(8'h55);
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("FAIL bad_csum_pulse_len: err=%b required 0", cmd_err);
    end
    send(8'hAA); send(8'h02); send(8'h04); send(8'h06);
    checks++;
    if (ctrl_command !== 4'd2 || value_command !== 4'd4 || cmd_update !== 1'b1) begin
      errors++;
      $display("FAIL after_bad_frame: ctrl=%0d val=%0d upd=%b, required 2/4/1",
               ctrl_command, value_command, cmd_update);
    end
  endtask

  task automatic test_focus_and_resync();
    send(8'h55); send(8'hAA); send(8'h01); send(8'h07); send(8'h08);
    checks++;
    if (cmd_err !== 1'b1 || err_cnt !== 8'd2 || ctrl_command !== 4'd2 || value_command !== 4'd4) begin
      errors++;
      $display("FAIL focus_range: err=%b cnt=%0d ctrl=%0d val=%0d, required 1/2/2/4",
               cmd_err, err_cnt, ctrl_command, value_command);
    end
    send(8'h12);
    checks++;
    if (busy !== 1'b0 || cmd_err !== 1'b0) begin
      errors++; $display("FAIL noise_ignored: busy=%b err=%b, required 0/0", busy, cmd_err);
    end
    send(8'h55); send(8'h55);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL resync_busy: busy=%b required 1", busy);
    end
    send(8'hAA); send(8'h00); send(8'h02); send(8'h02);
    checks++;
    if (ctrl_command !== 4'd0 || value_command !== 4'd2 || cmd_update !== 1'b1 ||
        cmd_err !== 1'b0 || err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL resync_frame: ctrl=%0d val=%0d upd=%b err=%b cnt=%0d, required 0/2/1/0/2",
               ctrl_command, value_command, cmd_update, cmd_err, err_cnt);
    end
    // identical frame is still accepted and still pulses
    send(8'h55); send(8'hAA); send(8'h00); send(8'h02); send(8'h02);
    checks++;
    if (cmd_update !== 1'b1) begin
      errors++; $display("FAIL same_frame: upd=%b required 1", cmd_update);
    end
    // upper nibble set in VALUE with a correct checksum
    send(8'h55); send(8'hAA); send(8'h03); send(8'h12); send(8'h15);
    checks++;
    if (cmd_err !== 1'b1 || ctrl_command !== 4'd0 || value_command !== 4'd2) begin
      errors++;
      $display("FAIL upper_nibble: err=%b ctrl=%0d val=%0d, required 1/0/2",
               cmd_err, ctrl_command, value_command);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      send(8'h55); send(8'hAA); send(8'h01); send(8'h03); send(8'h05);
      if (i == 251) begin
        checks++;
        if (err_cnt !== 8'd255) begin
          errors++; $display("FAIL err_cnt_reach: cnt=%0d required 255", err_cnt);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'hFF || cmd_err !== 1'b1 || err_cnt !== m_cnt) begin
      errors++;
      $display("FAIL err_cnt_saturate: cnt=%0d err=%b, required 255/1", err_cnt, cmd_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    send(8'h55); send(8'hAA); send(8'h01);
    apply_reset();
    checks++;
    if (ctrl_command !== 4'd0 || value_command !== 4'd1 || err_cnt !== 8'd0 ||
        busy !== 1'b0 || cmd_update !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_reset: ctrl=%0d val=%0d cnt=%0d busy=%b upd=%b err=%b, required 0/1/0/0/0/0",
               ctrl_command, value_command, err_cnt, busy, cmd_update, cmd_err);
    end
    send(8'h03); send(8'h04);   // leftover tail of the old frame: ignored
    send(8'h55); send(8'hAA); send(8'h02); send(8'h04); send(8'h06);
    checks++;
    if (ctrl_command !== 4'd2 || value_command !== 4'd4 || cmd_update !== 1'b1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_frame: ctrl=%0d val=%0d upd=%b cnt=%0d, required 2/4/1/0",
               ctrl_command, value_command, cmd_update, err_cnt);
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    apply_reset();
    send(8'h55); send(8'hAA);
    bad = 0;
    for (int i = 1; i < TMO; i++) begin
      drive(1'b0, 8'h00);
      if (busy !== 1'b1 || cmd_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL timeout_early: %0d early cycles, required 0", bad);
    end
    drive(1'b0, 8'h00);
    checks++;
    if (busy !== 1'b0 || cmd_err !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL timeout_fire: busy=%b err=%b cnt=%0d, required 0/1/1", busy, cmd_err, err_cnt);
    end
    bad = 0;
    send(8'h01); if (cmd_update !== 1'b0) bad++;
    send(8'h02); if (cmd_update !== 1'b0) bad++;
    send(8'h03); if (cmd_update !== 1'b0) bad++;
    drive(1'b0, 8'h00);
    checks++;
    if (bad != 0 || ctrl_command !== 4'd0 || value_command !== 4'd1) begin
      errors++;
      $display("FAIL timeout_tail: updates=%0d ctrl=%0d val=%0d, required 0/0/1",
               bad, ctrl_command, value_command);
    end
  endtask
`endif

  // Random frames, noise and gaps; every cycle compared against the model.
  task automatic test_random();
    logic [8:0] stim_q[$];   // {valid, byte}
    logic [7:0] c, v, s;
    int kind;
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 6);
      c = 8'($urandom_range(0, 15));
      v = (c == 8'd1) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(0, 15));
      case (kind)
        1: c = c | 8'h10 << $urandom_range(0, 3);        // upper nibble set
        2: v = 8'(5 + $urandom_range(0, 10));             // may break focus range
        default: ;
      endcase
      s = c + v;
      if (kind == 3) s = s ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 4) stim_q.push_back({1'b1, 8'($urandom_range(0, 255))});
      if (kind == 5) stim_q.push_back({1'b1, 8'h55});
      stim_q.push_back({1'b1, 8'h55});
      if (kind == 6) stim_q.push_back({1'b1, 8'($urandom_range(0, 255))});
      stim_q.push_back({1'b1, 8'hAA});
      stim_q.push_back({1'b1, c});
      stim_q.push_back({1'b1, v});
      stim_q.push_back({1'b1, s});
    end
    foreach (stim_q[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 8'h00);
      end
      drive(stim_q[i][8], stim_q[i][7:0]);
      checks++;
      if (ctrl_command !== m_ctrl || value_command !== m_val || cmd_update !== m_upd ||
          cmd_err !== m_err || err_cnt !== m_cnt || busy !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL random[%0d]: ctrl=%0d val=%0d upd=%b err=%b cnt=%0d busy=%b, required %0d/%0d/%b/%b/%0d/%b",
                 i, ctrl_command, value_command, cmd_update, cmd_err, err_cnt, busy,
                 m_ctrl, m_val, m_upd, m_err, m_cnt, (exp_q.size() != 0));
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    test_reset();
    test_basic();
    test_bad_csum();
    test_focus_and_resync();
    test_saturation();
    test_reset_mid_frame();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    apply_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/cmd_frame_decoder.md
Name: cmd_frame_decoder

Overview:
- Upstream control stage for the multi-channel splicing top. It sits between the UART receiver and the splicing top.
- It parses a fixed 5-byte command frame from the host byte stream.
- It validates each frame and drives the registered 4-bit `ctrl_command` and `value_command` buses that select the layout mode and the focus source (CAM_1=1, CAM_2=2, CAM_FUSION=3, HDMI=4).
- Outputs change only after a complete, error-free frame. Bad frames are dropped and counted.

Parameters:
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.
- RST_CTRL, 4'd0, ctrl_command value after reset.
- RST_VALUE, 4'd1, value_command value after reset (CAM_1).
- FOCUS_CTRL, 4'd1, ctrl code whose value field must lie in 1..4.
- TIMEOUT_CYCLES, 24'd5_000_000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic is single-domain on this clock.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- ctrl_command  output  4  registered layout/control command.
- value_command  output  4  registered value/focus-source command.
- cmd_update  output  1  one-cycle pulse when the command outputs are loaded.
- cmd_err  output  1  one-cycle pulse when a frame is rejected.
- err_cnt  output  8  saturating count of rejected frames.
- busy  output  1  high while the FSM is not in S_IDLE.

Behaviour:
- Frame format: HDR0, HDR1, CTRL, VALUE, CSUM, where CSUM = (CTRL + VALUE) mod 256.
- A byte is consumed only in a cycle with rx_valid=1. Cycles without rx_valid never change state.
- Reset values: ctrl_command=RST_CTRL; value_command=RST_VALUE; cmd_update=0; cmd_err=0; err_cnt=0; busy=0; state=S_IDLE. Reset is applied asynchronously at any point; a partial frame is discarded with no pulse.
- FSM states: S_IDLE, S_HDR1, S_CTRL, S_VAL, S_CSUM.
  - S_IDLE: byte==HDR0 -> S_HDR1. Any other byte is ignored silently (no error).
  - S_HDR1:
    - byte==HDR1 -> S_CTRL.
    - byte==HDR0 -> stay in S_HDR1 (resync).
    - any other byte -> S_IDLE, no error.
  - S_CTRL: latch the byte into ctrl_reg -> S_VAL.
  - S_VAL: latch the byte into val_reg -> S_CSUM.
  - S_CSUM: evaluate the frame, then -> S_IDLE in all cases.
- Frame check in S_CSUM. The frame is accepted only if all three hold:
  - checksum matches;
  - ctrl_reg[7:4]==0 and val_reg[7:4]==0;
  - if ctrl_reg[3:0]==FOCUS_CTRL, then val_reg[3:0] is in 1..4.
- Accepted frame: ctrl_command and value_command load ctrl_reg[3:0] and val_reg[3:0] on the clock edge after the CSUM byte. cmd_update is high for exactly that one cycle. Latency is 1 clk from the CSUM rx_valid to the outputs.
- Rejected frame: outputs hold their previous values. cmd_err pulses high for 1 cycle at the same latency. err_cnt increments and saturates at 8'hFF with no wrap.
- cmd_update and cmd_err are never high in the same cycle.
- A frame identical to the current outputs is still accepted and still pulses cmd_update.
- Bytes arriving back-to-back (rx_valid high every cycle) are fully supported, with no dead cycle between frames. A new HDR0 may arrive in the cycle immediately after CSUM.
- busy = (state != S_IDLE), registered.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- When defined:
  - A 24-bit counter clears on every rx_valid and counts every clk while state != S_IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to S_IDLE, cmd_err pulses once and err_cnt increments (saturating).
  - An rx_valid arriving in the same cycle as the timeout takes priority: the byte is processed and the counter clears.
- When undefined: no counter exists, and the FSM waits indefinitely for the next byte.

Test Plan:
- Reset then idle -> ctrl_command=0, value_command=1, err_cnt=0, busy=0, no pulses.
- Bytes 55 AA 01 03 04 (back-to-back) -> one clk after 04: ctrl_command=1, value_command=3, cmd_update high for 1 cycle, busy=0.
- Bytes 55 AA 01 03 05 (bad checksum) -> cmd_err 1-cycle pulse, err_cnt=1, outputs unchanged. Then 55 AA 02 04 06 -> ctrl=2, value=4.
- Bytes 55 AA 01 07 08 (focus value out of range) -> cmd_err pulse, outputs hold. Bytes 12 55 55 AA 00 02 02 (noise plus resync) -> accepted: ctrl=0, value=2, no cmd_err.
- 300 consecutive bad-checksum frames -> err_cnt stops at 8'hFF. Assert rst mid-frame after 55 AA 01 -> outputs return to 0/1, err_cnt=0; the next valid frame decodes normally.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 55 AA then stall -> at cycle 100, busy falls, cmd_err pulses, err_cnt+1. Sending 01 02 03 afterwards yields no update.
